// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum and bit-timing helper used by rx and tx.
package uart_pkg;

    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned MIN_TICKS_PER_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Zero baud yields zero so the elaboration check reports it instead of dividing by zero.
    function automatic int unsigned ticks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        if (baud == 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; UART_RX_MAJORITY_EN adds a 2-of-3 glitch filter.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_bit,
    output logic o_s_c
);

    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_bit};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    // Vote over the current and two previous synchronizer outputs.
    assign o_s_c = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign o_s_c = r_sync[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
// Optional glitch filter in uart_rx_sync is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 0,
    parameter int unsigned BAUD_RATE   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] byte_out_data,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned TICKS_PER_BIT = ticks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned HALF          = TICKS_PER_BIT / 2;
    localparam int unsigned CNT_W         = $clog2(TICKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);

    generate
        if (TICKS_PER_BIT < MIN_TICKS_PER_BIT) begin : g_bad_rate
            $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 8");
        end
    endgenerate

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte_data;
    logic             r_byte_valid;
    logic             r_frame_error;
    logic             r_overrun;
    logic             w_s;
    logic             w_sample_bit;
    logic             w_deliver;
    logic             w_frame_err;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .i_bit (bit_in),
        .o_s_c (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the one-cycle sample/deliver strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_bit = 1'b0;
        w_deliver    = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == CNT_HALF_LAST) begin
                    w_state_nxt = w_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_sample_bit = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_state_nxt = IDLE;
                    w_deliver   = w_s;
                    w_frame_err = !w_s;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Tick counter restarts on every state change and at each data-bit midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (w_sample_bit) begin
            r_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else begin
            if (w_sample_bit) begin
                r_shift <= {w_s, r_shift[7:1]};
            end
            if (r_state != DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample_bit) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Output register: a full slot keeps its byte and flags the newcomer as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_data   <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_frame_err;
            r_overrun     <= 1'b0;
            if (w_deliver && (!r_byte_valid || byte_out_ready)) begin
                r_byte_data  <= r_shift;
                r_byte_valid <= 1'b1;
            end else if (w_deliver) begin
                r_overrun <= 1'b1;
            end else if (r_byte_valid && byte_out_ready) begin
                r_byte_valid <= 1'b0;
            end
        end
    end

    assign byte_out_data  = r_byte_data;
    assign byte_out_valid = r_byte_valid;
    assign frame_error    = r_frame_error;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver feeds frames, a monitor checks the byte stream.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 62_500;
    localparam int          TPB    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       ready;
    logic [7:0] byte_out_data;
    logic       byte_out_valid;
    logic       frame_error;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bit_in         (bit_in),
        .byte_out_data  (byte_out_data),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (ready),
        .frame_error    (frame_error),
        .overrun        (overrun)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         exp_fe  = 0;
    int         exp_ov  = 0;
    int         seen_fe = 0;
    int         seen_ov = 0;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled mid-low-phase, so valid&&ready here means a transfer at the next edge.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (byte_out_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", byte_out_data);
                end else begin
                    check("rx_byte", int'(byte_out_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_error) begin
                seen_fe++;
                check("frame_error_width", int'(prev_fe), 0);
            end
            if (overrun) begin
                seen_ov++;
                check("overrun_width", int'(prev_ov), 0);
            end
        end
        prev_fe = frame_error;
        prev_ov = overrun;
    end

    task automatic drive(input logic v, input int n);
        bit_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Serial transmitter model: start, 8 data bits LSB first, stop; optional 1-cycle glitch mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int glitch_bit);
        drive(1'b0, TPB);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(b[i], TPB / 2);
                drive(~b[i], 1);
                drive(b[i], TPB / 2 - 1);
            end else begin
                drive(b[i], TPB);
            end
        end
        drive(stop_ok, TPB);
        bit_in = 1'b1;
    endtask

    // Reference: a good frame yields its byte unless the 1-deep output is full and not draining.
    task automatic expect_frame(input logic [7:0] b, input logic stop_ok, input logic slot_full);
        if (!stop_ok) begin
            exp_fe++;
        end else if (slot_full && !ready) begin
            exp_ov++;
        end else begin
            exp_q.push_back(b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int         kind;
        rst    = 1'b1;
        bit_in = 1'b1;
        ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("reset_valid", int'(byte_out_valid), 0);
        check("reset_data", int'(byte_out_data), 0);
        check("reset_frame_error", int'(frame_error), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_state_idle", int'(dut.r_state), int'(IDLE));

        expect_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, -1);
        drive(1'b1, 20);

        drive(1'b0, 5);
        drive(1'b1, 20);
        check("false_start_idle", int'(dut.r_state), int'(IDLE));

        expect_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, -1);
        drive(1'b1, 24);
        expect_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, -1);
        drive(1'b1, 4);

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom);
            if (kind == 0) begin
                drive(1'b0, int'($urandom_range(1, 6)));
                drive(1'b1, 14);
            end else if (kind == 1) begin
                expect_frame(b, 1'b0, 1'b0);
                send_frame(b, 1'b0, -1);
                drive(1'b1, 24);
            end else begin
                expect_frame(b, 1'b1, 1'b0);
                send_frame(b, 1'b1, -1);
                drive(1'b1, int'($urandom_range(0, 12)));
            end
        end
        drain();
        check("frame_error_count", seen_fe, exp_fe);

        ready = 1'b0;
        expect_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, -1);
        expect_frame(8'h02, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, -1);
        drive(1'b1, 6);
        #2;
        check("held_valid", int'(byte_out_valid), 1);
        check("held_data", int'(byte_out_data), 8'h01);
        check("overrun_count", seen_ov, exp_ov);
        @(negedge clk);
        ready = 1'b1;
        drain();
        #2;
        check("valid_drops_after_pop", int'(byte_out_valid), 0);

        ready = 1'b0;
        send_frame(8'h77, 1'b1, -1);
        drive(1'b1, 4);
        fork
            send_frame(8'hFF, 1'b1, -1);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        drive(1'b1, 4);
        #2;
        check("valid_after_abort", int'(byte_out_valid), 0);
        @(negedge clk);
        ready = 1'b1;
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, -1);
        drive(1'b1, 4);
        drain();

`ifdef UART_RX_MAJORITY_EN
        expect_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 3);
        drive(1'b1, 4);
        drain();
`endif

        check("final_frame_error_count", seen_fe, exp_fe);
        check("final_overrun_count", seen_ov, exp_ov);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
